iir_voice_sequencer: RTL and testbench

IIR_VOICE_SEQUENCER -- requirements
Module: iir_voice_sequencer

---
 rtl/iir_voice_sequencer_pkg.sv | 27 ++
 rtl/iir_voice_sequencer.sv | 147 ++++++++++++++
 tb/tb_iir_voice_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_voice_sequencer_pkg.sv
// Shared widths, state encoding and voice-pointer helper for the voice sequencer
// that time-shares one 8-slot IIR filter across all voices.
package iir_voice_sequencer_pkg;

  localparam int NV_DEF    = 8;
  localparam int ACC_W_DEF = 21;
  localparam int DATA_W    = 18;
  localparam int DEL_W     = 36;
  localparam int SEL_W     = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT1   = 3'd2,
    WAIT2   = 3'd3,
    COLLECT = 3'd4,
    DONE    = 3'd5
  } state_t;

  function automatic logic [SEL_W-1:0] next_voice(input logic [SEL_W-1:0] v, input int nv);
    logic [SEL_W-1:0] nxt;
    if (v == SEL_W'(nv - 1)) nxt = {SEL_W{1'b0}};
    else nxt = v + {{(SEL_W-1){1'b0}}, 1'b1};
    return nxt;
  endfunction

endpackage

// File: rtl/iir_voice_sequencer.sv
// Per sample frame, feeds every voice through the shared IIR filter one slot at a
// time (4 cycles per voice) and sums the filter outputs into mix_out.
module iir_voice_sequencer
  import iir_voice_sequencer_pkg::*;
#(
  parameter int NV    = NV_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_tick,
  output logic [SEL_W-1:0]         vsel,
  input  logic signed [DATA_W-1:0] voice_in,
  input  logic signed [DEL_W-1:0]  del_in,
  input  logic [7:0]               voice_en,
  output logic                     f_ena,
  output logic signed [DATA_W-1:0] f_I,
  output logic signed [DEL_W-1:0]  f_DEL,
  output logic [SEL_W-1:0]         f_SEL,
  input  logic signed [DATA_W-1:0] f_O,
  output logic signed [ACC_W-1:0]  mix_out,
  output logic                     mix_valid,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  state_t                    state_r, state_s;
  logic [SEL_W-1:0]          v_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [ACC_W-1:0]   f_o_ext_s;
  logic                      f_ena_r;
  logic [SEL_W-1:0]          f_sel_r;
  logic signed [DATA_W-1:0]  f_i_r;
  logic signed [DEL_W-1:0]   f_del_r;
  logic signed [ACC_W-1:0]   mix_out_r;
  logic                      mix_valid_r;
  logic                      busy_r;
  logic                      overrun_r;
  logic                      start_s;
  logic                      issue_s;
  logic                      last_s;
  logic                      ovr_set_s;

  assign f_o_ext_s = {{(ACC_W-DATA_W){f_O[DATA_W-1]}}, f_O};

  // Next-state decode plus the frame-start, issue and overrun strobes.
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    issue_s   = 1'b0;
    last_s    = (f_sel_r == SEL_W'(NV - 1));
    ovr_set_s = sample_tick && (state_r != IDLE);
    case (state_r)
      IDLE: begin
        if (sample_tick) begin
          state_s = ISSUE;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE:   state_s = WAIT1;
      WAIT1:   state_s = WAIT2;
      WAIT2:   state_s = COLLECT;
      COLLECT: begin
        if (last_s) state_s = DONE;
        else state_s = ISSUE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    issue_s = (state_s == ISSUE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else state_r <= state_s;
  end

  // Voice pointer steps at WAIT2 so that during COLLECT vsel already names the
  // next voice, whose sample is then captured on the edge that enters ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= {SEL_W{1'b0}};
    end else if (start_s) begin
      v_r <= {SEL_W{1'b0}};
    end else if (state_r == WAIT2) begin
      v_r <= next_voice(v_r, NV);
    end
  end

  // Filter request registers, loaded on entry to ISSUE and held for the slot window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_ena_r <= 1'b0;
      f_sel_r <= {SEL_W{1'b0}};
      f_i_r   <= {DATA_W{1'b0}};
      f_del_r <= {DEL_W{1'b0}};
    end else begin
      f_ena_r <= issue_s;
      if (issue_s) begin
        f_sel_r <= v_r;
        f_i_r   <= voice_en[v_r] ? voice_in : {DATA_W{1'b0}};
        f_del_r <= del_in;
      end
    end
  end

  // Mix accumulator (wrapping) and the per-frame result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= {ACC_W{1'b0}};
      mix_out_r   <= {ACC_W{1'b0}};
      mix_valid_r <= 1'b0;
    end else begin
      if (start_s) acc_r <= {ACC_W{1'b0}};
      else if (state_r == COLLECT) acc_r <= acc_r + f_o_ext_s;
      if (state_r == DONE) mix_out_r <= acc_r;
      mix_valid_r <= (state_r == DONE);
    end
  end

  // Busy and sticky overrun; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      if (ovr_set_s) overrun_r <= 1'b1;
      else if (ovr_clr) overrun_r <= 1'b0;
    end
  end

  assign vsel      = v_r;
  assign f_ena     = f_ena_r;
  assign f_SEL     = f_sel_r;
  assign f_I       = f_i_r;
  assign f_DEL     = f_del_r;
  assign mix_out   = mix_out_r;
  assign mix_valid = mix_valid_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_iir_voice_sequencer.sv
// Scoreboard bench: a behavioural 8-slot IIR filter sits beside the sequencer and a
// frame-level reference model predicts every filter request and every mix result.
module tb_iir_voice_sequencer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sample_tick = 1'b0;
  logic               ovr_clr = 1'b0;
  logic [2:0]         vsel;
  logic signed [17:0] voice_in;
  logic signed [35:0] del_in;
  logic [7:0]         voice_en;
  logic               f_ena;
  logic signed [17:0] f_I;
  logic signed [35:0] f_DEL;
  logic [2:0]         f_SEL;
  logic signed [17:0] f_O = 18'sd0;
  logic signed [20:0] mix_out;
  logic               mix_valid;
  logic               busy;
  logic               overrun;

  typedef struct { logic [2:0] sel; logic signed [17:0] i; logic signed [35:0] d; int cyc; } iss_t;
  typedef struct { logic signed [63:0] mix; int cyc; } mix_t;

  iss_t issq[$];
  mix_t mixq[$];

  logic signed [17:0] cur_v [8];
  logic signed [35:0] cur_d [8];
  logic [7:0]         cur_en = 8'h00;
  logic signed [17:0] ref_st [8] = '{default: 18'sd0};
  logic signed [17:0] fst [8] = '{default: 18'sd0};
  logic signed [17:0] p1 = 18'sd0, p2 = 18'sd0;

  int n_cmp = 0, n_bad = 0, cyc = 0, mv_seen = 0, hold_cnt = 0;
  bit hold_ok;
  logic [2:0] h_sel;
  logic signed [17:0] h_i;
  logic signed [35:0] h_d;

  assign voice_in = cur_v[vsel];
  assign del_in   = cur_d[vsel];
  assign voice_en = cur_en;

  iir_voice_sequencer #(.NV(8), .ACC_W(21)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .vsel(vsel),
    .voice_in(voice_in), .del_in(del_in), .voice_en(voice_en),
    .f_ena(f_ena), .f_I(f_I), .f_DEL(f_DEL), .f_SEL(f_SEL), .f_O(f_O),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-pole filter: y = sat18((I*(1-2^-17) + y_prev*coef) >> 17), coef = DEL[35:18] in Q1.17.
  function automatic logic signed [17:0] filt(input logic signed [17:0] i,
                                               input logic signed [35:0] d,
                                               input logic signed [17:0] yp);
    longint acc;
    longint coef;
    logic signed [17:0] c18;
    c18  = d[35:18];
    coef = longint'(c18);
    acc  = longint'(i) * 64'sd131071 + longint'(yp) * coef;
    acc  = acc >>> 17;
    if (acc > 64'sd131071) acc = 64'sd131071;
    else if (acc < -64'sd131072) acc = -64'sd131072;
    return acc[17:0];
  endfunction

  // Shared filter stand-in: unreset slot state, result valid 3 cycles after f_ena.
  always @(posedge clk) begin
    if (f_ena) begin
      fst[f_SEL] <= filt(f_I, f_DEL, fst[f_SEL]);
      p1         <= filt(f_I, f_DEL, fst[f_SEL]);
    end
    p2  <= p1;
    f_O <= p2;
  end

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations as the DUT presents filter requests and mix results.
  initial begin
    iss_t e;
    mix_t m;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_cnt = 0;
      end else begin
        if (hold_cnt > 0) begin
          if (f_ena !== 1'b0 || f_SEL !== h_sel || f_I !== h_i || f_DEL !== h_d) hold_ok = 1'b0;
          hold_cnt--;
          if (hold_cnt == 0) check("slot_window_hold", hold_ok, 1);
        end
        if (f_ena === 1'b1) begin
          if (issq.size() == 0) begin
            check("unexpected_f_ena", f_ena, 0);
          end else begin
            e = issq.pop_front();
            check("f_SEL", f_SEL, e.sel);
            check("f_I", f_I, e.i);
            check("f_DEL", f_DEL, e.d);
            check("f_ena_cycle", cyc, e.cyc);
            h_sel = f_SEL; h_i = f_I; h_d = f_DEL;
            hold_ok = 1'b1;
            hold_cnt = 3;
          end
        end
        if (mix_valid === 1'b1) begin
          mv_seen++;
          if (mixq.size() == 0) begin
            check("unexpected_mix_valid", mix_valid, 0);
          end else begin
            m = mixq.pop_front();
            check("mix_out", mix_out, m.mix);
            check("mix_valid_cycle", cyc, m.cyc);
          end
        end
      end
    end
  end

  task automatic set_all(input logic signed [17:0] vv, input logic [7:0] en, input logic signed [35:0] dd);
    for (int v = 0; v < 8; v++) begin
      cur_v[v] = vv;
      cur_d[v] = dd;
    end
    cur_en = en;
  endtask

  task automatic set_random();
    for (int v = 0; v < 8; v++) begin
      cur_v[v] = 18'($urandom);
      cur_d[v] = 36'({$urandom, $urandom});
    end
    cur_en = 8'($urandom);
  endtask

  // Predict the whole frame, queue the expectations, then pulse sample_tick.
  task automatic start_frame(output int c);
    iss_t e;
    mix_t m;
    logic signed [63:0] mix;
    iss_t es [8];
    mix = 64'sd0;
    for (int v = 0; v < 8; v++) begin
      es[v].sel = 3'(v);
      es[v].i   = cur_en[v] ? cur_v[v] : 18'sd0;
      es[v].d   = cur_d[v];
      ref_st[v] = filt(es[v].i, cur_d[v], ref_st[v]);
      mix       = mix + 64'(ref_st[v]);
    end
    @(negedge clk);
    c = cyc;
    for (int v = 0; v < 8; v++) begin
      e = es[v];
      e.cyc = c + 1 + 4 * v;
      issq.push_back(e);
    end
    m.mix = mix;
    m.cyc = c + 34;
    mixq.push_back(m);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((mixq.size() != 0 || busy !== 1'b0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("frame_timeout_pending", 64'(mixq.size()) + 64'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    int c, mv0;
    set_all(18'sd0, 8'h00, 36'sd0);
    repeat (3) @(negedge clk);
    check("rst_f_ena", f_ena, 0);
    check("rst_f_SEL", f_SEL, 0);
    check("rst_f_I", f_I, 0);
    check("rst_f_DEL", f_DEL, 0);
    check("rst_mix_out", mix_out, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_vsel", vsel, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    set_all(18'sd65536, 8'hFF, 36'sd0);
    start_frame(c);
    check("busy_in_frame", busy, 1);
    wait_done();
    check("mix_all_voices", mix_out, 64'sd524280);

    set_all(18'sd65536, 8'h01, 36'sd0);
    start_frame(c);
    wait_done();
    check("mix_voice0_only", mix_out, 64'sd65535);
    repeat (3) @(negedge clk);
    check("mix_out_held", mix_out, 64'sd65535);

    // Overrun: tick mid-frame, clear, clear colliding with a set, tick during DONE.
    set_random();
    start_frame(c);
    wait_cyc(c + 10);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("overrun_set", overrun, 1);
    wait_done();
    check("overrun_sticky", overrun, 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("overrun_cleared", overrun, 0);
    set_random();
    start_frame(c);
    wait_cyc(c + 10);
    sample_tick = 1'b1;
    ovr_clr = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    ovr_clr = 1'b0;
    check("overrun_set_beats_clr", overrun, 1);
    wait_done();
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    set_random();
    start_frame(c);
    wait_cyc(c + 33);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("overrun_tick_in_done", overrun, 1);
    @(negedge clk);
    check("no_frame_from_done_tick", busy, 0);
    repeat (6) @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;

    // Reset in the middle of a frame aborts it without a mix_valid pulse.
    set_all(18'sd40000, 8'hFF, 36'sd0);
    start_frame(c);
    wait_cyc(c + 17);
    #2 rst_n = 1'b0;
    #1;
    check("abort_f_ena", f_ena, 0);
    check("abort_busy", busy, 0);
    check("abort_mix_valid", mix_valid, 0);
    check("abort_mix_out", mix_out, 0);
    issq.delete();
    mixq.delete();
    mv0 = mv_seen;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(c + 45);
    check("abort_no_mix_valid", mv_seen - mv0, 0);

    set_all(18'sd65536, 8'hFF, 36'sd0);
    start_frame(c);
    wait_done();
    check("frame_after_abort", mix_out, 64'sd524280);

    // Zero input with half feedback: every slot decays from 65535.
    set_all(18'sd0, 8'hFF, 36'sh400000000);
    start_frame(c);
    wait_done();
    check("decay_step1", mix_out, 64'sd262136);
    start_frame(c);
    wait_done();
    check("decay_step2", mix_out, 64'sd131064);

    set_all(-18'sd65536, 8'hFF, 36'sd0);
    start_frame(c);
    wait_done();
    check("mix_negative", mix_out, -64'sd524288);

    for (int n = 0; n < 12; n++) begin
      set_random();
      start_frame(c);
      wait_done();
    end

    check("queues_drained", 64'(issq.size()) + 64'(mixq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
